uart_baud_ctrl: RTL

Baud-rate configuration controller for the UART. Arbitrates divisor-change requests from the software register port and the auto-baud detector, validates them, and drains the link by holding TX off new frames. Once TX and RX have both been idle for a programmable quiet window, it commits the new divisor to the baud clock generator. It is the only driver of the generator's `baud_divisor` input.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_quiet_timer.sv | 39 +++
 rtl/uart_baud_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART baud-configuration types: reset divisor, FSM state and request-source encodings.
package uart_pkg;

    localparam int unsigned DEFAULT_DIV = 5208;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    typedef enum logic {
        SRC_SW = 1'b0,
        SRC_AB = 1'b1
    } src_e;

endpackage

// File: rtl/uart_quiet_timer.sv
// Counts consecutive cycles with TX and RX both idle; flags the edge that completes the quiet window.
module uart_quiet_timer #(
    parameter int QUIET_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tx_idle,
    input  logic rx_idle,
    output logic quiet_hit
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       both_idle;

    assign both_idle = tx_idle & rx_idle;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || !both_idle) begin
            cnt_d = '0;
        end else if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Window completes on the edge that would make the count reach QUIET_CYCLES.
    assign quiet_hit = ~clear & both_idle & (cnt_q == 8'(QUIET_CYCLES - 1));

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud divisor change controller: sw/ab arbitration, validation, link drain and commit.
// Optional drain abort timer enabled by defining UART_BAUD_TIMEOUT_EN.
module uart_baud_ctrl #(
    parameter int DEFAULT_DIV    = 5208,
    parameter int MIN_DIV        = 16,
    parameter int QUIET_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw_req_valid,
    input  logic [15:0] sw_req_div,
    output logic        sw_req_ready,
    input  logic        ab_req_valid,
    input  logic [15:0] ab_req_div,
    output logic        ab_req_ready,
    input  logic        tx_idle,
    input  logic        rx_idle,
    output logic        tx_hold,
    output logic [15:0] baud_divisor,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        cfg_src
);

    import uart_pkg::*;

    if (QUIET_CYCLES < 1 || QUIET_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("uart_baud_ctrl: QUIET_CYCLES must be 1..255 and TIMEOUT_CYCLES >= 1");
    end

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [15:0] pdiv_q, pdiv_d;
    logic        src_q, src_d;
    logic        psrc_q, psrc_d;
    logic        hold_q, hold_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        grant_sw, grant_ab;
    logic [15:0] sel_div;
    logic        sel_src;
    logic        quiet_hit;
    logic        tmo_hit;

    // Fixed priority: sw always wins a tie; the loser keeps valid and retries.
    assign grant_sw     = (state_q == ST_IDLE) & sw_req_valid;
    assign grant_ab     = (state_q == ST_IDLE) & ab_req_valid & ~sw_req_valid;
    assign sw_req_ready = grant_sw;
    assign ab_req_ready = grant_ab;
    assign sel_div      = grant_sw ? sw_req_div : ab_req_div;
    assign sel_src      = grant_sw ? SRC_SW : SRC_AB;

    uart_quiet_timer #(
        .QUIET_CYCLES(QUIET_CYCLES)
    ) u_quiet (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q != ST_DRAIN),
        .tx_idle  (tx_idle),
        .rx_idle  (rx_idle),
        .quiet_hit(quiet_hit)
    );

`ifdef UART_BAUD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q <= '0;
        end else if (state_q != ST_DRAIN) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_q + 1'b1;
        end
    end

    assign tmo_hit = (state_q == ST_DRAIN) && (tmr_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pdiv_d  = pdiv_q;
        src_d   = src_q;
        psrc_d  = psrc_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_sw || grant_ab) begin
                    if (sel_div < 16'(MIN_DIV)) begin
                        err_d = 1'b1;
                    end else if (sel_div == div_q) begin
                        done_d = 1'b1;
                        src_d  = sel_src;
                    end else begin
                        pdiv_d  = sel_div;
                        psrc_d  = sel_src;
                        hold_d  = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Commit takes precedence over a coincident timeout.
                if (quiet_hit) begin
                    div_d   = pdiv_q;
                    src_d   = psrc_q;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            div_q   <= 16'(DEFAULT_DIV);
            pdiv_q  <= '0;
            src_q   <= 1'b0;
            psrc_q  <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pdiv_q  <= pdiv_d;
            src_q   <= src_d;
            psrc_q  <= psrc_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tx_hold      = hold_q;
    assign baud_divisor = div_q;
    assign cfg_busy     = (state_q != ST_IDLE);
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign cfg_src      = src_q;

endmodule
